// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// access-size encodings, FSM state type, timeout default and the
// store-lane helpers used when a request is latched.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Default abort threshold for the optional BUSY timeout.
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // An access is rejected when its size is illegal or its address is
    // not naturally aligned for that size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE:    bad = 1'b0;
            SZ_HALF:    bad = off[0];
            SZ_WORD:    bad = (off != 2'b00);
            SZ_ILLEGAL: bad = 1'b1;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for the addressed lanes; loads and stores share them.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across all lanes so the memory
    // picks the right bytes purely from the enables.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        r = wd;
        case (size)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_formatter.sv
// Load formatter: selects the addressed lane of a raw 32-bit read word and
// sign- or zero-extends it according to the access size.
module load_formatter
    import dmem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] lane;

    // Shift the addressed byte lane down to bit 0, then extend.
    always_comb begin
        lane     = raw_i >> {offset_i, 3'b000};
        result_o = lane;
        case (size_i)
            SZ_BYTE: result_o = {{24{lane[7]  & ~unsigned_i}}, lane[7:0]};
            SZ_HALF: result_o = {{16{lane[15] & ~unsigned_i}}, lane[15:0]};
            default: result_o = lane;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit. Issues load/store requests over a
// req/ack handshake, stalls the pipeline while an access is outstanding and
// returns a registered, formatted load result for the writeback select.
// Optional feature macro: DMEM_TIMEOUT_EN (aborts a request that sees no ack
// within TIMEOUT_CYCLES BUSY cycles and pulses bus_error).
//
// Memory handshake: dmem_req rises the cycle after an access is accepted and
// dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_be stay constant until the first
// cycle in which dmem_ack is sampled high while dmem_req is high; that cycle
// completes the transfer (dmem_rdata is taken in the same cycle) and dmem_req
// is low the next cycle. dmem_ack while no request is pending is ignored.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [DATA_W/8-1:0]   dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic [DATA_W-1:0]     dmem_read_data,
    output logic                  read_valid,
    output logic                  stall,
    output logic                  misaligned_fault,
    output logic                  bus_error,
    output logic [1:0]            dbg_state
);

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W/8-1:0]  be_q, be_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [1:0]           off_q, off_d;
    logic [DATA_W-1:0]    rd_q, rd_d;
    logic                 rvalid_q, rvalid_d;
    logic                 fault_q, fault_d;
    logic                 berr_q, berr_d;

    logic                 access;
    logic                 misaligned;
    logic [DATA_W-1:0]    fmt_data;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_hit;
    // The last allowed BUSY cycle is the one where the count equals
    // TIMEOUT_CYCLES-1, so the request stays up exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) & ~dmem_ack;
`endif

    // A store wins when both read and write are flagged.
    assign access     = in_valid & (mem_read | mem_write);
    assign misaligned = is_misaligned(mem_size, addr[1:0]);

    load_formatter u_load_formatter (
        .raw_i      (dmem_rdata),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (fmt_data)
    );

    // Next-state and registered-output computation for the IDLE/BUSY/DONE FSM.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        size_d   = size_q;
        uns_d    = uns_q;
        off_d    = off_q;
        rd_d     = rd_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        berr_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        wdata_d = replicate(mem_size, wdata);
                        be_d    = lane_enables(mem_size, addr[1:0]);
                        size_d  = mem_size;
                        uns_d   = mem_unsigned;
                        off_d   = addr[1:0];
                        state_d = ST_BUSY;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rd_d     = fmt_data;
                        rvalid_d = 1'b1;
                    end
`ifdef DMEM_TIMEOUT_EN
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rd_d     = '0;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_DONE: begin
                // The completed instruction is still on the inputs here;
                // the pipeline advances at the end of this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            berr_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            berr_q   <= berr_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Stall covers the accepting IDLE cycle and every BUSY cycle; it is held
    // low while reset is asserted.
    always_comb begin
        stall = rst_n & (((state_q == ST_IDLE) & access & ~misaligned) |
                         (state_q == ST_BUSY));
    end

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign dmem_be          = be_q;
    assign dmem_read_data   = rd_q;
    assign read_valid       = rvalid_q;
    assign misaligned_fault = fault_q;
    assign bus_error        = berr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: load/store formatting, latency,
// misaligned rejection, reset during BUSY and the optional timeout.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] dmem_read_data;
  logic        read_valid;
  logic        stall;
  logic        misaligned_fault;
  logic        bus_error;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  dmem_access_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_size         (mem_size),
    .mem_unsigned     (mem_unsigned),
    .addr             (addr),
    .wdata            (wdata),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_be          (dmem_be),
    .dmem_ack         (dmem_ack),
    .dmem_rdata       (dmem_rdata),
    .dmem_read_data   (dmem_read_data),
    .read_valid       (read_valid),
    .stall            (stall),
    .misaligned_fault (misaligned_fault),
    .bus_error        (bus_error),
    .dbg_state        (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    in_valid     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = SZ_WORD;
    mem_unsigned = 1'b0;
    addr         = 32'h0;
    wdata        = 32'h0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    in_valid     = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    addr         = a;
    wdata        = wd;
  endtask

  // One complete aligned access; the memory acks after 'waits' extra cycles.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_res);
    logic is_load;
    logic [31:0] got;
    is_load = rd & ~wr;
    @(negedge clk);
    drive(rd, wr, sz, uns, a, wd);
    #1 chk({tag, ":accept_stall"}, 32'(stall), 32'd1);
    if (is_load) exp_q.push_back(exp_res);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk({tag, ":req"}, 32'(dmem_req), 32'd1);
      chk({tag, ":stall"}, 32'(stall), 32'd1);
      chk({tag, ":addr"}, dmem_addr, exp_addr);
      chk({tag, ":be"}, 32'(dmem_be), 32'(exp_be));
      chk({tag, ":wdata"}, dmem_wdata, exp_wdata);
      chk({tag, ":we"}, 32'(dmem_we), 32'(wr));
      if (i == waits) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
    end
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom();
    chk({tag, ":done_req"}, 32'(dmem_req), 32'd0);
    chk({tag, ":done_stall"}, 32'(stall), 32'd0);
    chk({tag, ":read_valid"}, 32'(read_valid), 32'(is_load));
    chk({tag, ":bus_error"}, 32'(bus_error), 32'd0);
    if (read_valid) begin
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk({tag, ":result"}, dmem_read_data, got);
        last_rd = got;
      end else begin
        chk({tag, ":unexpected_result"}, dmem_read_data, 32'hxxxx_xxxx);
      end
    end
    idle_inputs();
    @(negedge clk);
    chk({tag, ":rv_pulse_end"}, 32'(read_valid), 32'd0);
    chk({tag, ":rd_hold"}, dmem_read_data, last_rd);
  endtask

  task automatic bad_access(input string tag, input logic [1:0] sz, input logic [31:0] a);
    @(negedge clk);
    drive(1'b1, 1'b0, sz, 1'b0, a, 32'h0);
    #1 chk({tag, ":no_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    idle_inputs();
    chk({tag, ":fault"}, 32'(misaligned_fault), 32'd1);
    chk({tag, ":no_req"}, 32'(dmem_req), 32'd0);
    chk({tag, ":idle"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, ":rd_unchanged"}, dmem_read_data, last_rd);
    @(negedge clk);
    chk({tag, ":fault_pulse"}, 32'(misaligned_fault), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rdat;
    int          w;
    idle_inputs();
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    last_rd    = 32'h0;

    // reset, with a valid aligned access pending to show stall is forced low
    repeat (3) @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
    #1 chk("rst:stall", 32'(stall), 32'd0);
    chk("rst:req", 32'(dmem_req), 32'd0);
    chk("rst:we", 32'(dmem_we), 32'd0);
    chk("rst:addr", dmem_addr, 32'd0);
    chk("rst:wdata", dmem_wdata, 32'd0);
    chk("rst:be", 32'(dmem_be), 32'd0);
    chk("rst:rd", dmem_read_data, 32'd0);
    chk("rst:rv", 32'(read_valid), 32'd0);
    chk("rst:fault", 32'(misaligned_fault), 32'd0);
    chk("rst:berr", 32'(bus_error), 32'd0);
    chk("rst:state", 32'(dbg_state), 32'(ST_IDLE));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    access("wload", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
           32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("bload_s", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h80123456, 0,
           32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    access("bload_u", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h80123456, 1,
           32'h100, 4'b1000, 32'h0, 32'h00000080);
    access("hstore", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 3,
           32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
    access("hload_s", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 32'hF00D1234, 0,
           32'h100, 4'b1100, 32'h0, 32'hFFFFF00D);
    access("hload_u", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 32'hF00D9234, 0,
           32'h100, 4'b0011, 32'h0, 32'h00009234);
    access("bstore_rw", 1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h301, 32'h1234565A, 32'h0, 1,
           32'h300, 4'b0010, 32'h5A5A5A5A, 32'h0);
    access("wstore", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h404, 32'hCAFEF00D, 32'h0, 0,
           32'h404, 4'b1111, 32'hCAFEF00D, 32'h0);

    for (int k = 0; k < 4; k++) begin
      ra   = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
      rdat = $urandom();
      w    = $urandom_range(0, 2);
      access("rand_wload", 1'b1, 1'b0, SZ_WORD, 1'b0, ra, 32'h0, rdat, w,
             ra, 4'b1111, 32'h0, rdat);
    end

    bad_access("mis_word", SZ_WORD, 32'h101);
    bad_access("mis_half", SZ_HALF, 32'h201);
    bad_access("mis_size", SZ_ILLEGAL, 32'h300);

    // ack while idle must not produce a result
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("idle_ack:rv", 32'(read_valid), 32'd0);
    chk("idle_ack:rd", dmem_read_data, last_rd);
    chk("idle_ack:state", 32'(dbg_state), 32'(ST_IDLE));
    dmem_ack = 1'b0;

    // reset while BUSY
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h500, 32'h0);
    repeat (3) @(negedge clk);
    chk("rstbusy:req_before", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1 chk("rstbusy:stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("rstbusy:req", 32'(dmem_req), 32'd0);
    chk("rstbusy:state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rstbusy:addr", dmem_addr, 32'd0);
    chk("rstbusy:be", 32'(dmem_be), 32'd0);
    chk("rstbusy:rd", dmem_read_data, 32'd0);
    chk("rstbusy:rv", 32'(read_valid), 32'd0);
    last_rd = 32'h0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // long wait without ack
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h600, 32'h0);
`ifdef DMEM_TIMEOUT_EN
    exp_q.push_back(32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo:req_held", 32'(dmem_req), 32'd1);
    end
    @(negedge clk);
    chk("tmo:req_drop", 32'(dmem_req), 32'd0);
    chk("tmo:bus_error", 32'(bus_error), 32'd1);
    chk("tmo:rv", 32'(read_valid), 32'd1);
    if (read_valid && exp_q.size() > 0) chk("tmo:result", dmem_read_data, exp_q.pop_front());
    idle_inputs();
    @(negedge clk);
    chk("tmo:berr_pulse", 32'(bus_error), 32'd0);
`else
    exp_q.push_back(32'h12345678);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("notmo:req_held", 32'(dmem_req), 32'd1);
      chk("notmo:bus_error", 32'(bus_error), 32'd0);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("notmo:rv", 32'(read_valid), 32'd1);
    if (read_valid && exp_q.size() > 0) chk("notmo:result", dmem_read_data, exp_q.pop_front());
    idle_inputs();
    @(negedge clk);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
MEM-stage data-memory access unit. It sits between the EX/MEM pipeline register and the writeback select.
- Issues load/store requests to data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Delivers byte/half/word-aligned, sign- or zero-extended load data on dmem_read_data, registered, for the writeback select.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
TIMEOUT_CYCLES, 16, cycles in BUSY before abort; used only with DMEM_TIMEOUT_EN

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  in  1  EX/MEM slot holds a valid instruction
mem_read  in  1  instruction is a load
mem_write  in  1  instruction is a store
mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_unsigned  in  1  zero-extend loads when 1
addr  in  32  byte address (ALU result)
wdata  in  32  store data, right-justified
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  memory completes the request this cycle
dmem_rdata  in  32  raw read word, valid with dmem_ack
dmem_read_data  out  32  formatted load result, registered
read_valid  out  1  one-cycle pulse: dmem_read_data updated by a load
stall  out  1  pipeline must hold EX/MEM and earlier stages
misaligned_fault  out  1  one-cycle pulse: misaligned or illegal access rejected
bus_error  out  1  one-cycle pulse: access aborted by timeout (feature only)

Behaviour:
- Reset (rst_n low at edge): state=IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be = 0.
  - dmem_read_data = 0, read_valid = 0, misaligned_fault = 0, bus_error = 0.
  - stall forced 0 while rst_n low.
- A reset asserted in BUSY drops dmem_req immediately. Memory tolerates a dropped request.
- access = in_valid & (mem_read | mem_write). If both mem_read and mem_write are set, treat as store.
- Misaligned or illegal when any of:
  - mem_size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
- FSM states IDLE, BUSY, DONE:
  - IDLE, access and aligned:
    - Register dmem_addr, dmem_we, dmem_wdata, dmem_be, size, unsigned flag and addr[1:0].
    - Set dmem_req=1 and go to BUSY.
  - IDLE, access and misaligned:
    - No request is issued.
    - misaligned_fault=1 next cycle; dmem_read_data unchanged; stay in IDLE.
  - BUSY:
    - dmem_req and all request fields are held stable until dmem_ack.
    - On dmem_ack:
      - dmem_req=0 next cycle.
      - For a load, dmem_read_data <= formatted(dmem_rdata) and read_valid=1 next cycle.
      - Go to DONE.
  - DONE: one cycle, then unconditionally IDLE. Inputs still present the completed instruction in this cycle and are ignored.
- stall = (IDLE & access & aligned) | BUSY. stall=0 in DONE, so the pipeline advances at the end of DONE.
- Latency with dmem_ack in the first request cycle:
  - accept at cycle N; req high at N+1; result and read_valid at N+2.
  - stall is high at N and N+1.
- Each extra ack wait adds one cycle.
- Store lanes:
  - byte: wdata={4{wdata[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{wdata[15:0]}}, be=4'b0011<<addr[1:0]
  - word: wdata=wdata, be=4'b1111
- Loads drive the same be values.
- Load format:
  - lane = dmem_rdata >> (8*addr[1:0]).
  - byte: bits[7:0] are sign-extended from bit 7, or zero-extended if mem_unsigned.
  - half: bits[15:0], extended from bit 15 in the same way.
  - word: passed through.
- dmem_read_data holds its value until the next completed load.
- A store completion does not pulse read_valid.
- dmem_ack outside BUSY is ignored.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack:
    - dmem_req=0 next cycle.
    - bus_error pulses 1 cycle.
    - dmem_read_data <= 0 for loads, with read_valid pulsed.
    - Go to DONE.
  - An ack in the same cycle as the timeout wins; it is a normal completion.
- Undefined: no counter; BUSY waits indefinitely; bus_error tied 0.

Decomposition:
- Shared package dmem_pkg holds:
  - mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state enum
  - TIMEOUT_CYCLES default
- One natural sub-module: load_formatter. It is combinational lane select plus sign/zero extension: inputs raw word, addr[1:0], size, unsigned; output 32-bit result.

Test Plan:
- Word load addr=0x100, dmem_rdata=0xDEADBEEF, ack in first BUSY cycle -> dmem_addr=0x100, be=1111, stall high 2 cycles, dmem_read_data=0xDEADBEEF with read_valid at N+2.
- Signed byte load addr=0x103, rdata=0x80123456 -> be=1000, result 0xFFFFFF80. Same access unsigned -> 0x00000080.
- Half store addr=0x202, wdata=0x0000ABCD, ack after 3 wait cycles -> dmem_wdata=0xABCDABCD, be=1100, we=1, req held stable 4 cycles, no read_valid.
- Word load addr=0x101 -> no dmem_req, misaligned_fault one pulse, stall never high, dmem_read_data unchanged.
- rst_n low during BUSY -> next cycle dmem_req=0, state IDLE, all outputs at reset values.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> req dropped after 16 BUSY cycles, bus_error pulse, result 0. Without the macro -> req remains high.
